// File: rtl/rs_bank.sv
// rs_bank: reservation-station bank with oldest-first multi-port issue.
// RS_DEPTH entries are shared by DISPATCH_W dispatch lanes, CDB_W wakeup
// channels and ISSUE_W issue ports. An age matrix keeps relative dispatch
// order, so it never wraps however long the bank runs.
// Optional feature macro: RS_CDB_BYPASS_EN. When defined, an entry whose
// missing operands are all on the CDB this cycle is eligible for select and
// issues with the broadcast values.

`ifndef XLEN
`define XLEN 64
`endif
`ifndef ROBLEN
`define ROBLEN 32
`endif

module rs_bank #(
    parameter int RS_DEPTH   = 8,
    parameter int DISPATCH_W = 3,
    parameter int CDB_W      = 3,
    parameter int ISSUE_W    = 2,
    parameter int TAG_W      = $clog2(`ROBLEN),
    parameter int PAYLOAD_W  = 64,
    localparam int XLEN      = `XLEN,
    localparam int CNT_W     = $clog2(RS_DEPTH + 1)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            squash,
    input  logic [DISPATCH_W-1:0]           dp_valid,
    input  logic [DISPATCH_W*TAG_W-1:0]     dp_T,
    input  logic [DISPATCH_W-1:0]           dp_rdy1,
    input  logic [DISPATCH_W-1:0]           dp_rdy2,
    input  logic [DISPATCH_W*TAG_W-1:0]     dp_T1,
    input  logic [DISPATCH_W*TAG_W-1:0]     dp_T2,
    input  logic [DISPATCH_W*XLEN-1:0]      dp_V1,
    input  logic [DISPATCH_W*XLEN-1:0]      dp_V2,
    input  logic [DISPATCH_W*PAYLOAD_W-1:0] dp_payload,
    input  logic [CDB_W-1:0]                cdb_valid,
    input  logic [CDB_W*TAG_W-1:0]          cdb_tag,
    input  logic [CDB_W*XLEN-1:0]           cdb_value,
    input  logic [ISSUE_W-1:0]              fu_ready,
    output logic [CNT_W-1:0]                free_slots,
    output logic [ISSUE_W-1:0]              is_valid,
    output logic [ISSUE_W*TAG_W-1:0]        is_T,
    output logic [ISSUE_W*XLEN-1:0]         is_V1,
    output logic [ISSUE_W*XLEN-1:0]         is_V2,
    output logic [ISSUE_W*PAYLOAD_W-1:0]    is_payload
);

    // Registered entry state
    logic [RS_DEPTH-1:0]  busy, rdy1, rdy2;
    logic [TAG_W-1:0]     t_q  [RS_DEPTH];
    logic [TAG_W-1:0]     t1_q [RS_DEPTH];
    logic [TAG_W-1:0]     t2_q [RS_DEPTH];
    logic [XLEN-1:0]      v1_q [RS_DEPTH];
    logic [XLEN-1:0]      v2_q [RS_DEPTH];
    logic [PAYLOAD_W-1:0] pl_q [RS_DEPTH];
    // older[i][j] set means entry i was dispatched before entry j
    logic [RS_DEPTH-1:0]  older      [RS_DEPTH];
    logic [RS_DEPTH-1:0]  older_next [RS_DEPTH];

    // Combinational views
    logic                 flush;
    logic [RS_DEPTH-1:0]  alloc, taken, issued, busy_next, ready_e;
    int                   alloc_lane [RS_DEPTH];
    logic [DISPATCH_W-1:0] cap_rdy1, cap_rdy2;
    logic [XLEN-1:0]      cap_v1 [DISPATCH_W];
    logic [XLEN-1:0]      cap_v2 [DISPATCH_W];
    logic [RS_DEPTH-1:0]  wk1, wk2;
    logic [XLEN-1:0]      wk_v1  [RS_DEPTH];
    logic [XLEN-1:0]      wk_v2  [RS_DEPTH];
    logic [XLEN-1:0]      eff_v1 [RS_DEPTH];
    logic [XLEN-1:0]      eff_v2 [RS_DEPTH];
    int                   rank   [RS_DEPTH];
    logic [CNT_W-1:0]     free_next;
    logic [ISSUE_W-1:0]   sel_valid;
    logic [ISSUE_W*TAG_W-1:0]     iss_T;
    logic [ISSUE_W*XLEN-1:0]      iss_V1, iss_V2;
    logic [ISSUE_W*PAYLOAD_W-1:0] iss_payload;

    assign flush = reset | squash;

    // Returns {hit, value}; the lowest matching channel wins.
    function automatic logic [XLEN:0] cdb_match(
        input logic [TAG_W-1:0]       tag,
        input logic [CDB_W-1:0]       vld,
        input logic [CDB_W*TAG_W-1:0] tags,
        input logic [CDB_W*XLEN-1:0]  vals
    );
        logic [XLEN:0] r;
        r = '0;
        for (int c = CDB_W - 1; c >= 0; c--) begin
            if (vld[c] && tags[c*TAG_W +: TAG_W] == tag)
                r = {1'b1, vals[c*XLEN +: XLEN]};
        end
        return r;
    endfunction

    // Lane-to-entry allocation (lowest free entry first) and dispatch-time CDB capture
    always_comb begin
        // NOTE: every variable written here gets a default before any branch, so no latch is inferred.
        alloc = '0;
        taken = busy;
        for (int i = 0; i < RS_DEPTH; i++) alloc_lane[i] = 0;
        for (int l = 0; l < DISPATCH_W; l++) begin
            logic          placed;
            logic [XLEN:0] m1, m2;
            placed = 1'b0;
            if (dp_valid[l] && !flush) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (!placed && !taken[i]) begin
                        placed        = 1'b1;
                        taken[i]      = 1'b1;
                        alloc[i]      = 1'b1;
                        alloc_lane[i] = l;
                    end
                end
            end
            m1 = cdb_match(dp_T1[l*TAG_W +: TAG_W], cdb_valid, cdb_tag, cdb_value);
            m2 = cdb_match(dp_T2[l*TAG_W +: TAG_W], cdb_valid, cdb_tag, cdb_value);
            cap_rdy1[l] = dp_rdy1[l] | m1[XLEN];
            cap_rdy2[l] = dp_rdy2[l] | m2[XLEN];
            cap_v1[l]   = dp_rdy1[l] ? dp_V1[l*XLEN +: XLEN] : m1[XLEN-1:0];
            cap_v2[l]   = dp_rdy2[l] ? dp_V2[l*XLEN +: XLEN] : m2[XLEN-1:0];
        end
    end

    // Per-entry CDB wakeup match and readiness seen by select
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            logic [XLEN:0] m1, m2;
            m1       = cdb_match(t1_q[i], cdb_valid, cdb_tag, cdb_value);
            m2       = cdb_match(t2_q[i], cdb_valid, cdb_tag, cdb_value);
            wk1[i]   = m1[XLEN];
            wk2[i]   = m2[XLEN];
            wk_v1[i] = m1[XLEN-1:0];
            wk_v2[i] = m2[XLEN-1:0];
`ifdef RS_CDB_BYPASS_EN
            ready_e[i] = busy[i] && (rdy1[i] || wk1[i]) && (rdy2[i] || wk2[i]);
            eff_v1[i]  = rdy1[i] ? v1_q[i] : wk_v1[i];
            eff_v2[i]  = rdy2[i] ? v2_q[i] : wk_v2[i];
`else
            ready_e[i] = busy[i] && rdy1[i] && rdy2[i];
            eff_v1[i]  = v1_q[i];
            eff_v2[i]  = v2_q[i];
`endif
        end
    end

    // Oldest-first select: port k among ready ports takes the entry with rank k
    always_comb begin
        int slot;
        issued      = '0;
        sel_valid   = '0;
        iss_T       = '0;
        iss_V1      = '0;
        iss_V2      = '0;
        iss_payload = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            rank[i] = 0;
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (j != i && ready_e[j] && older[j][i]) rank[i]++;
            end
        end
        slot = 0;
        for (int p = 0; p < ISSUE_W; p++) begin
            if (fu_ready[p]) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (ready_e[i] && rank[i] == slot) begin
                        sel_valid[p] = 1'b1;
                        issued[i]    = 1'b1;
                        iss_T[p*TAG_W +: TAG_W]               = t_q[i];
                        iss_V1[p*XLEN +: XLEN]                = eff_v1[i];
                        iss_V2[p*XLEN +: XLEN]                = eff_v2[i];
                        iss_payload[p*PAYLOAD_W +: PAYLOAD_W] = pl_q[i];
                    end
                end
                slot++;
            end
        end
    end

    // Next occupancy and age matrix: new entries are younger than all others,
    // and within one bundle the lower lane is older
    always_comb begin
        busy_next = (busy & ~issued) | alloc;
        free_next = CNT_W'(RS_DEPTH - $countones(busy_next));
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (alloc[i])
                    older_next[i][j] = alloc[j] && (alloc_lane[i] < alloc_lane[j]);
                else if (alloc[j])
                    older_next[i][j] = 1'b1;
                else
                    older_next[i][j] = older[i][j];
            end
        end
    end

    // Control state and registered issue outputs, cleared by reset or squash
    always_ff @(posedge clock) begin
        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
        if (flush) begin
            busy       <= '0;
            free_slots <= CNT_W'(RS_DEPTH);
            is_valid   <= '0;
            is_T       <= '0;
            is_V1      <= '0;
            is_V2      <= '0;
            is_payload <= '0;
        end else begin
            busy       <= busy_next;
            free_slots <= free_next;
            is_valid   <= sel_valid;
            is_T       <= iss_T;
            is_V1      <= iss_V1;
            is_V2      <= iss_V2;
            is_payload <= iss_payload;
        end
    end

    // Entry payload, operand capture and wakeup
    always_ff @(posedge clock) begin
        // NOTE: entry storage has no reset; busy qualifies every use, and allocation rewrites all fields.
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (alloc[i]) begin
                t_q[i]  <= dp_T[alloc_lane[i]*TAG_W +: TAG_W];
                t1_q[i] <= dp_T1[alloc_lane[i]*TAG_W +: TAG_W];
                t2_q[i] <= dp_T2[alloc_lane[i]*TAG_W +: TAG_W];
                pl_q[i] <= dp_payload[alloc_lane[i]*PAYLOAD_W +: PAYLOAD_W];
                rdy1[i] <= cap_rdy1[alloc_lane[i]];
                rdy2[i] <= cap_rdy2[alloc_lane[i]];
                v1_q[i] <= cap_v1[alloc_lane[i]];
                v2_q[i] <= cap_v2[alloc_lane[i]];
            end else begin
                if (busy[i] && !rdy1[i] && wk1[i]) begin
                    rdy1[i] <= 1'b1;
                    v1_q[i] <= wk_v1[i];
                end
                if (busy[i] && !rdy2[i] && wk2[i]) begin
                    rdy2[i] <= 1'b1;
                    v2_q[i] <= wk_v2[i];
                end
            end
        end
        older <= older_next;
    end

`ifndef SYNTHESIS
    // Dispatch must not offer more lanes than free entries; a full bank simply ignores lanes
    always_ff @(posedge clock) begin
        if (!flush && free_slots != '0)
            assert ($countones(dp_valid) <= int'(free_slots))
            else $error("rs_bank: %0d dispatch lanes offered with %0d free entries",
                        $countones(dp_valid), free_slots);
    end
`endif

endmodule

// File: tb/tb_rs_bank.sv
// tb_rs_bank: directed self-checking bench for rs_bank (default parameters,
// TAG_W=5, XLEN=64). Expectations for RS_CDB_BYPASS_EN follow the macro.

module tb_rs_bank;

    localparam int DW = 3, CW = 3, IW = 2, TW = 5, XL = 64, PW = 64, CNT_W = 4;

    logic              clock = 1'b0;
    logic              reset, squash;
    logic [DW-1:0]     dp_valid, dp_rdy1, dp_rdy2;
    logic [DW*TW-1:0]  dp_T, dp_T1, dp_T2;
    logic [DW*XL-1:0]  dp_V1, dp_V2;
    logic [DW*PW-1:0]  dp_payload;
    logic [CW-1:0]     cdb_valid;
    logic [CW*TW-1:0]  cdb_tag;
    logic [CW*XL-1:0]  cdb_value;
    logic [IW-1:0]     fu_ready;
    logic [CNT_W-1:0]  free_slots;
    logic [IW-1:0]     is_valid;
    logic [IW*TW-1:0]  is_T;
    logic [IW*XL-1:0]  is_V1, is_V2;
    logic [IW*PW-1:0]  is_payload;

    int n_checks = 0;
    int n_pass   = 0;

    rs_bank #(.RS_DEPTH(8), .DISPATCH_W(DW), .CDB_W(CW), .ISSUE_W(IW),
              .TAG_W(TW), .PAYLOAD_W(PW)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .dp_valid(dp_valid), .dp_T(dp_T), .dp_rdy1(dp_rdy1), .dp_rdy2(dp_rdy2),
        .dp_T1(dp_T1), .dp_T2(dp_T2), .dp_V1(dp_V1), .dp_V2(dp_V2),
        .dp_payload(dp_payload), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .fu_ready(fu_ready), .free_slots(free_slots),
        .is_valid(is_valid), .is_T(is_T), .is_V1(is_V1), .is_V2(is_V2),
        .is_payload(is_payload)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] fs();        return 64'(free_slots); endfunction
    function automatic logic [63:0] vld();       return 64'(is_valid); endfunction
    function automatic logic [63:0] it(int p);   return 64'(is_T[p*TW +: TW]); endfunction
    function automatic logic [63:0] iv1(int p);  return is_V1[p*XL +: XL]; endfunction
    function automatic logic [63:0] iv2(int p);  return is_V2[p*XL +: XL]; endfunction
    function automatic logic [63:0] ipl(int p);  return is_payload[p*PW +: PW]; endfunction
    function automatic logic [63:0] pl_of(int t); return 64'hA5A5_0000_0000_0000 | 64'(t); endfunction

    task automatic idle();
        dp_valid = '0; dp_rdy1 = '0; dp_rdy2 = '0;
        dp_T = '0; dp_T1 = '0; dp_T2 = '0;
        dp_V1 = '0; dp_V2 = '0; dp_payload = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
        squash = 1'b0;
    endtask

    task automatic lane(input int l, input int t, input bit r1, input int t1, input logic [63:0] v1,
                        input bit r2, input int t2, input logic [63:0] v2);
        dp_valid[l]              = 1'b1;
        dp_T[l*TW +: TW]         = TW'(t);
        dp_rdy1[l]               = r1;
        dp_T1[l*TW +: TW]        = TW'(t1);
        dp_V1[l*XL +: XL]        = v1;
        dp_rdy2[l]               = r2;
        dp_T2[l*TW +: TW]        = TW'(t2);
        dp_V2[l*XL +: XL]        = v2;
        dp_payload[l*PW +: PW]   = pl_of(t);
    endtask

    task automatic cdb(input int c, input int tag, input logic [63:0] v);
        cdb_valid[c]            = 1'b1;
        cdb_tag[c*TW +: TW]     = TW'(tag);
        cdb_value[c*XL +: XL]   = v;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset, with dispatch and CDB activity that must be ignored
        idle();
        fu_ready = 2'b11;
        reset = 1'b1;
        lane(0, 30, 1, 0, 64'h1, 1, 0, 64'h2);
        cdb(0, 3, 64'h3);
        tick(); tick();
        check("rst_free", fs(), 8);
        check("rst_valid", vld(), 0);
        check("rst_T", 64'(is_T), 0);
        check("rst_V1", iv1(0), 0);
        idle();
        reset = 1'b0;
        tick();
        check("rst_no_alloc_valid", vld(), 0);
        check("rst_no_alloc_free", fs(), 8);

        // Three ready lanes: two issue next, the third after
        lane(0, 1, 1, 0, 64'd5, 1, 0, 64'd7);
        lane(1, 2, 1, 0, 64'd5, 1, 0, 64'd7);
        lane(2, 3, 1, 0, 64'd5, 1, 0, 64'd7);
        tick();
        check("d3_free", fs(), 5);
        check("d3_valid", vld(), 0);
        idle();
        tick();
        check("d3_iss_valid", vld(), 2'b11);
        check("d3_iss_T0", it(0), 1);
        check("d3_iss_T1", it(1), 2);
        check("d3_iss_V1", iv1(0), 5);
        check("d3_iss_V2", iv2(1), 7);
        check("d3_iss_pl", ipl(0), pl_of(1));
        check("d3_free2", fs(), 7);
        tick();
        check("d3_last_valid", vld(), 2'b01);
        check("d3_last_T", it(0), 3);
        check("d3_free3", fs(), 8);
        tick();
        check("d3_drained", vld(), 0);

        // CDB wakeup of a waiting operand
        lane(0, 9, 0, 4, 64'h0, 1, 0, 64'h1);
        tick();
        check("wk_free", fs(), 7);
        idle();
        tick();
        check("wk_wait", vld(), 0);
        cdb(0, 4, 64'h1234);
        tick();
        idle();
`ifdef RS_CDB_BYPASS_EN
        check("wk_byp_valid", vld(), 1);
        check("wk_byp_V1", iv1(0), 64'h1234);
        check("wk_byp_T", it(0), 9);
`else
        check("wk_not_yet", vld(), 0);
`endif
        tick();
`ifdef RS_CDB_BYPASS_EN
        check("wk_byp_once", vld(), 0);
`else
        check("wk_valid", vld(), 1);
        check("wk_V1", iv1(0), 64'h1234);
        check("wk_V2", iv2(0), 64'h1);
        check("wk_T", it(0), 9);
`endif
        check("wk_free_end", fs(), 8);

        // Same-cycle capture at dispatch, lowest CDB channel wins
        lane(0, 11, 1, 0, 64'h3, 0, 6, 64'h0);
        lane(1, 12, 0, 7, 64'h0, 1, 0, 64'h2);
        cdb(0, 7, 64'h77);
        cdb(1, 7, 64'h88);
        cdb(2, 6, 64'hABCD);
        tick();
        check("cap_free", fs(), 6);
        check("cap_valid0", vld(), 0);
        idle();
        tick();
        check("cap_valid", vld(), 2'b11);
        check("cap_T0", it(0), 11);
        check("cap_V1_0", iv1(0), 64'h3);
        check("cap_V2_0", iv2(0), 64'hABCD);
        check("cap_T1", it(1), 12);
        check("cap_V1_1", iv1(1), 64'h77);
        check("cap_V2_1", iv2(1), 64'h2);
        check("cap_free2", fs(), 8);

        // Age order independent of slot index, one ready port
        fu_ready = 2'b00;
        lane(0, 10, 1, 0, 64'h0, 1, 0, 64'h0);
        lane(1, 13, 1, 0, 64'h0, 1, 0, 64'h0);
        tick();
        check("age_free_a", fs(), 6);
        idle();
        fu_ready = 2'b01;
        tick();
        check("age_F_valid", vld(), 2'b01);
        check("age_F_T", it(0), 10);
        fu_ready = 2'b00;
        lane(0, 14, 1, 0, 64'h0, 1, 0, 64'h0);
        tick();
        check("age_hold", vld(), 0);
        check("age_free_b", fs(), 6);
        idle();
        lane(0, 15, 1, 0, 64'h0, 1, 0, 64'h0);
        tick();
        check("age_free_c", fs(), 5);
        idle();
        fu_ready = 2'b01;
        tick();
        check("age_1st", it(0), 13);
        tick();
        check("age_2nd", it(0), 14);
        fu_ready = 2'b10;
        tick();
        check("age_3rd_valid", vld(), 2'b10);
        check("age_3rd", it(1), 15);
        check("age_free_end", fs(), 8);
        fu_ready = 2'b11;
        tick();
        check("age_drained", vld(), 0);

        // Fill the bank, then offer lanes to a full bank
        lane(0, 0, 0, 16, 64'h0, 1, 0, 64'h0);
        lane(1, 1, 0, 17, 64'h0, 1, 0, 64'h0);
        lane(2, 2, 0, 18, 64'h0, 1, 0, 64'h0);
        tick();
        check("fill_free1", fs(), 5);
        idle();
        lane(0, 3, 0, 19, 64'h0, 1, 0, 64'h0);
        lane(1, 4, 0, 20, 64'h0, 1, 0, 64'h0);
        lane(2, 5, 0, 21, 64'h0, 1, 0, 64'h0);
        tick();
        check("fill_free2", fs(), 2);
        idle();
        lane(0, 6, 0, 22, 64'h0, 1, 0, 64'h0);
        lane(1, 7, 0, 23, 64'h0, 1, 0, 64'h0);
        tick();
        check("fill_full", fs(), 0);
        idle();
        lane(0, 24, 1, 0, 64'h0, 1, 0, 64'h0);
        lane(1, 25, 1, 0, 64'h0, 1, 0, 64'h0);
        lane(2, 26, 1, 0, 64'h0, 1, 0, 64'h0);
        tick();
        check("full_ignored_free", fs(), 0);
        check("full_ignored_valid", vld(), 0);
        idle();
        tick();
        check("full_no_issue", vld(), 0);
        cdb(0, 19, 64'h33);
        tick();
        idle();
`ifdef RS_CDB_BYPASS_EN
        check("full_wk_valid", vld(), 2'b01);
        check("full_wk_T", it(0), 3);
        check("full_wk_V1", iv1(0), 64'h33);
`else
        check("full_wk_wait", vld(), 0);
`endif
        tick();
`ifdef RS_CDB_BYPASS_EN
        check("full_wk_once", vld(), 0);
`else
        check("full_wk_valid", vld(), 2'b01);
        check("full_wk_T", it(0), 3);
        check("full_wk_V1", iv1(0), 64'h33);
`endif
        check("full_one_free", fs(), 1);
        lane(0, 27, 0, 30, 64'h0, 1, 0, 64'h0);
        tick();
        check("full_refill", fs(), 0);
        idle();

        // Squash with concurrent dispatch and CDB match
        squash = 1'b1;
        lane(0, 28, 1, 0, 64'h0, 1, 0, 64'h0);
        cdb(0, 16, 64'h99);
        tick();
        check("sq_free", fs(), 8);
        check("sq_valid", vld(), 0);
        idle();
        tick();
        check("sq_valid2", vld(), 0);
        check("sq_free2", fs(), 8);
        cdb(0, 17, 64'h1);
        cdb(1, 18, 64'h2);
        cdb(2, 30, 64'h3);
        tick();
        idle();
        tick();
        check("sq_gone", vld(), 0);
        check("sq_free3", fs(), 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rs_bank.md
Name: rs_bank

Overview:
- Parametrised reservation-station bank: RS_DEPTH entries, up to DISPATCH_W inserts, CDB_W wakeup broadcasts and ISSUE_W issues per cycle.
- Sits between dispatch (tags from map table/ROB, values from regfile/ROB) and the functional units.
- Replaces per-line RS instances and adds oldest-first issue select, free-slot accounting and full squash.

Parameters:
RS_DEPTH, 8, number of entries (>=2)
DISPATCH_W, 3, dispatch lanes per cycle
CDB_W, 3, CDB broadcast channels
ISSUE_W, 2, issue ports per cycle
TAG_W, $clog2(`ROBLEN), ROB tag width
PAYLOAD_W, 64, opaque decoded-inst bits carried unchanged (inst, PC, NPC, selects, func, flags)

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
squash  in  1  branch mispredict; clears all entries
dp_valid  in  DISPATCH_W  lane carries an inst
dp_T  in  DISPATCH_W*TAG_W  destination ROB tag
dp_rdy1, dp_rdy2  in  DISPATCH_W each  operand already available
dp_T1, dp_T2  in  DISPATCH_W*TAG_W each  producer tag when not ready
dp_V1, dp_V2  in  DISPATCH_W*`XLEN each  operand value when ready
dp_payload  in  DISPATCH_W*PAYLOAD_W  carried fields
cdb_valid  in  CDB_W  broadcast valid
cdb_tag  in  CDB_W*TAG_W  broadcast tag
cdb_value  in  CDB_W*`XLEN  broadcast value
fu_ready  in  ISSUE_W  issue port may accept this cycle
free_slots  out  $clog2(RS_DEPTH+1)  entries not busy (registered)
is_valid  out  ISSUE_W  issue port carries an inst
is_T  out  ISSUE_W*TAG_W  issued dest tag
is_V1, is_V2  out  ISSUE_W*`XLEN each  issued operands
is_payload  out  ISSUE_W*PAYLOAD_W  issued fields

Behaviour:
- Entry state: busy, rdy1/rdy2, T, T1/T2, V1/V2, payload, age info. Reset or squash: all busy=0; free_slots=RS_DEPTH; is_valid=0; all is_* data outputs=0. Dispatch and CDB inputs in that cycle are ignored.
- Allocation: valid lanes fill free entries lowest index first, lane 0 taking the lowest free entry. Dispatch logic must not present more valid lanes than free_slots. Excess lanes are dropped, with an assertion under simulation.
- Dispatch capture, same cycle: an operand not dp_rdy whose dp_T matches any valid CDB channel is stored ready with the CDB value. On multiple matches, the lowest channel index wins.
- Wakeup: each busy, not-ready operand whose stored tag matches a valid CDB channel becomes ready next edge and latches the value. Ready operands are never overwritten.
- Ready entry: busy && rdy1 && rdy2, evaluated on registered state. Without the optional feature, an entry woken at edge N issues at edge N+1 at earliest.
- Select: combinational over registered state. Port k gets the k-th oldest ready entry among ports with fu_ready=1, assigned in ascending port order. Age is strictly by dispatch cycle; within one bundle, the lower lane is older. The age relation must survive unlimited operation without wrap errors (age matrix or equivalent).
- Issue outputs are registered. Entry selected in cycle N drives is_* from edge N+1 for one cycle and is cleared (busy=0) at that same edge. An entry is issued exactly once.
- A freed entry can be reallocated in the next cycle, never the same cycle.
- free_slots at edge N+1 = free_slots(N) − dispatched(N) + issued(N). Never exceeds RS_DEPTH.
- Full bank (free_slots=0): dispatch lanes are ignored. Issue and wakeup continue.
- Tag 0 is a legal tag. Readiness is carried only by rdy bits, never by tag value.

Optional Feature:
RS_CDB_BYPASS_EN
- Defined: select also treats an entry as ready when every not-ready operand matches a valid CDB tag this cycle. The issued operand takes the CDB value. Wakeup-to-issue latency drops by one cycle.
- Undefined: select uses registered rdy bits only.

Test Plan:
- Reset then dispatch 3 lanes, all operands ready (V1=5, V2=7) with fu_ready=2'b11 -> entries 0,1,2 allocated. Next cycle, lanes 0 and 1 issue with is_V1=5; lane 2 issues the cycle after. free_slots sequence: 8,5,7,8.
- Dispatch an inst with dp_T1=4 not ready; two cycles later cdb_tag=4, cdb_value=0x1234 -> is_V1=0x1234. Issue occurs 2 edges after the CDB without bypass, 1 edge with RS_CDB_BYPASS_EN.
- Dispatch with dp_T2=6 while cdb_valid[2] broadcasts tag 6 in the same cycle -> operand captured ready. Issue follows the next cycle with the CDB value.
- Fill all 8 entries, then present 3 more dispatch lanes -> no allocation, free_slots=0. After one issue, free_slots=1 and the next single dispatch is accepted.
- Three ready entries dispatched in cycles 1, 2, 3 (older in a higher index slot), ISSUE_W=1 -> issue order follows dispatch order, independent of slot index.
- Busy entries plus an asserted squash concurrent with a dispatch and a CDB match -> all entries cleared, is_valid=0 next cycle, free_slots=8.
